calc_key_sequencer: RTL and testbench

- Sits between the keypad scanner and the calculator core.
- Buffers decoded key codes in a small FIFO and replays them one at a time on the calculator's key_pressed/keypad_out interface.
- Key_pressed is driven as a clean pulse with a guaranteed low gap, so the calculator's edge detector and multi-state FSM always finish one key before the next arrives.
- A clear key (4'hE) pre-empts all queued keys.

---
 rtl/calc_key_sequencer.sv | 139 +++++++++++++
 tb/tb_calc_key_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// Key sequencer between the keypad scanner and the calculator core: buffers key codes
// and replays them as fixed-width key_pressed pulses with a guaranteed low gap.
module calc_key_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               in_code,
    output logic                     in_ready,
    input  logic                     clear_ovf,
    output logic                     key_pressed,
    output logic [3:0]               keypad_out,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    localparam logic [3:0]    CLEAR_CODE = 4'hE;
    localparam logic [AW:0]   PTR_ONE    = 1;
    localparam logic [AW:0]   FULL_LVL   = DEPTH;
    localparam logic [CW-1:0] CNT_ONE    = 1;
    localparam logic [CW-1:0] HOLD_LOAD  = HOLD_CYCLES - 1;
    localparam logic [CW-1:0] GAP_LOAD   = GAP_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          kp_n;
    logic [3:0]    code_n;

    logic [3:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, is_clear, do_push, do_pop, do_drop;

    // Pointers carry one extra bit so full and empty differ with equal indices
    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (fill_level == FULL_LVL);
    assign empty      = (wr_ptr == rd_ptr);
    assign in_ready   = !full;
    assign busy       = (state != IDLE) || !empty;

    assign is_clear = in_valid && (in_code == CLEAR_CODE);
    assign do_push  = in_valid && !full && !is_clear;
    assign do_drop  = in_valid && full && !is_clear;
    assign do_pop   = (state == IDLE) && !empty && !is_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (is_clear) begin
            // Flush and leave the clear code as the only entry; any pop is cancelled
            mem[0] <= CLEAR_CODE;
            wr_ptr <= PTR_ONE;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= in_code;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (do_drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_pressed <= 1'b0;
            keypad_out  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            key_pressed <= kp_n;
            keypad_out  <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        kp_n    = key_pressed;
        code_n  = keypad_out;
        case (state)
            IDLE: begin
                kp_n = 1'b0;
                if (do_pop) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LOAD;
                    kp_n    = 1'b1;
                    code_n  = mem[rd_ptr[AW-1:0]];
                end
            end
            HOLD: begin
                kp_n = 1'b1;
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
                    kp_n    = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            GAP: begin
                kp_n = 1'b0;
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                kp_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: directed stimulus queues expected codes,
// a negedge monitor checks every emitted pulse for code and width.
module tb_calc_key_sequencer;

    localparam int DEPTH   = 4;
    localparam int HOLD    = 4;
    localparam int GAP     = 8;
    localparam int SPACING = HOLD + GAP + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_code;
    logic       in_ready;
    logic       clear_ovf;
    logic       key_pressed;
    logic [3:0] keypad_out;
    logic       busy;
    logic       overflow;
    logic [$clog2(DEPTH):0] fill_level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] exp_q [$];
    int         rise_q [$];

    logic       mon_prev_kp = 1'b0;
    int         mon_hi_cnt  = 0;
    bit         mon_aborted = 1'b0;
    logic [3:0] mon_exp;

    calc_key_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .in_ready    (in_ready),
        .clear_ovf   (clear_ovf),
        .key_pressed (key_pressed),
        .keypad_out  (keypad_out),
        .busy        (busy),
        .overflow    (overflow),
        .fill_level  (fill_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input bit expect_out);
        in_valid = 1'b1;
        in_code  = c;
        if (expect_out) exp_q.push_back(c);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy && !key_pressed && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("drain_within_bound", ok, 1);
    endtask

    // Monitor: pops the scoreboard on every rising key_pressed, checks pulse width on fall
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (key_pressed === 1'b1 && mon_prev_kp !== 1'b1) begin
                rise_q.push_back(cyc);
                mon_hi_cnt  = 0;
                mon_aborted = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_key: got code %0h, required no key (cycle %0d)",
                             keypad_out, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("key_code", keypad_out, mon_exp);
                end
            end
            if (key_pressed === 1'b1) begin
                mon_hi_cnt++;
                if (rst) mon_aborted = 1'b1;
            end
            if (key_pressed === 1'b0 && mon_prev_kp === 1'b1 && !mon_aborted)
                check("hold_width", mon_hi_cnt, HOLD);
            mon_prev_kp = key_pressed;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        clear_ovf = 1'b0;
        repeat (3) step();

        check("rst_key_pressed", key_pressed, 0);
        check("rst_keypad_out",  keypad_out, 0);
        check("rst_overflow",    overflow, 0);
        check("rst_fill_level",  fill_level, 0);
        check("rst_busy",        busy, 0);
        check("rst_in_ready",    in_ready, 1);
        rst = 1'b0;
        step();

        // Single key
        push(4'h7, 1'b1);
        check("single_fill", fill_level, 1);
        check("single_latency_low", key_pressed, 0);
        step();
        for (int i = 0; i < HOLD; i++) begin
            check("single_hold_high", key_pressed, 1);
            check("single_code", keypad_out, 4'h7);
            step();
        end
        for (int i = 0; i < GAP; i++) begin
            check("single_gap_low", key_pressed, 0);
            check("single_code_held", keypad_out, 4'h7);
            step();
        end
        check("single_busy_done", busy, 0);
        check("single_code_idle", keypad_out, 4'h7);

        // Burst of three
        rise_q.delete();
        push(4'h1, 1'b1);
        check("burst_fill_a", fill_level, 1);
        push(4'h2, 1'b1);
        check("burst_fill_b", fill_level, 1);
        push(4'h3, 1'b1);
        check("burst_fill_peak", fill_level, 2);
        wait_idle(100);
        check("burst_pulses", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            check("burst_spacing_12", rise_q[1] - rise_q[0], SPACING);
            check("burst_spacing_23", rise_q[2] - rise_q[1], SPACING);
        end

        // Overflow: in_valid held six cycles regardless of in_ready
        rise_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_code = 4'(i + 1);
            check("ovf_in_ready", in_ready, (i < 5) ? 1 : 0);
            if (i == 5) check("ovf_not_yet", overflow, 0);
            if (i < 5) exp_q.push_back(4'(i + 1));
            step();
        end
        in_valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_fill_full", fill_level, DEPTH);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        wait_idle(150);
        check("ovf_pulses", rise_q.size(), 5);

        // Clear pre-emption while key 9 is active
        push(4'h9, 1'b1);
        step();
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        push(4'h3, 1'b1);
        check("clr_key9_hold", key_pressed, 1);
        check("clr_fill_before", fill_level, 3);
        exp_q.delete();
        exp_q.push_back(4'hE);
        in_valid = 1'b1;
        in_code  = 4'hE;
        step();
        in_valid = 1'b0;
        check("clr_fill_after_flush", fill_level, 1);
        check("clr_no_overflow", overflow, 0);
        wait_idle(100);

        // Reset during the second HOLD cycle with two entries queued
        push(4'h5, 1'b1);
        in_valid = 1'b1;
        in_code  = 4'h6;
        step();
        in_code  = 4'h7;
        step();
        in_valid = 1'b0;
        check("rstmid_fill_before", fill_level, 2);
        check("rstmid_kp_before", key_pressed, 1);
        exp_q.delete();
        rst = 1'b1;
        step();
        check("rstmid_key_pressed", key_pressed, 0);
        check("rstmid_fill", fill_level, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_keypad_out", keypad_out, 0);
        check("rstmid_in_ready", in_ready, 1);
        rst = 1'b0;
        rise_q.delete();
        repeat (2 * SPACING) step();
        check("rstmid_no_stale", rise_q.size(), 0);
        check("rstmid_fill_after", fill_level, 0);

        // Drop while full together with clear_ovf: set wins
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        push(4'h3, 1'b1);
        push(4'h4, 1'b1);
        push(4'h5, 1'b1);
        check("sim_fill_full", fill_level, DEPTH);
        check("sim_in_ready_low", in_ready, 0);
        clear_ovf = 1'b1;
        in_valid  = 1'b1;
        in_code   = 4'h8;
        step();
        in_valid  = 1'b0;
        clear_ovf = 1'b0;
        check("sim_ovf_set_wins", overflow, 1);
        check("sim_fill_unchanged", fill_level, DEPTH);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("sim_ovf_cleared", overflow, 0);
        wait_idle(150);

        // Clear push in the same cycle as an IDLE pop
        push(4'h3, 1'b1);
        exp_q.delete();
        exp_q.push_back(4'hE);
        in_valid = 1'b1;
        in_code  = 4'hE;
        step();
        in_valid = 1'b0;
        check("sim_pop_cancelled", key_pressed, 0);
        check("sim_flush_fill", fill_level, 1);
        step();
        check("sim_clear_emitted", key_pressed, 1);
        check("sim_clear_code", keypad_out, 4'hE);
        wait_idle(60);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
